// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared element/accumulator widths and sequencer state encoding
package npu_pkg;

  localparam int ELEM_W          = 8;
  localparam int ACC_W           = 16;
  localparam int VEC_LEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    WRITE,
    NEXT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/matmul_sequencer_vec_gather.sv
// rtl/matmul_sequencer_vec_gather.sv - vec_gather: sweeps one operand vector out of a 1-cycle-latency byte memory
module vec_gather
  import npu_pkg::*;
#(
  parameter int VEC_LEN = VEC_LEN_DEFAULT,
  parameter int AW      = 7
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [AW-1:0]                     base,
  output logic [AW-1:0]                     addr,
  input  logic [ELEM_W-1:0]                 rdata,
  output logic [0:VEC_LEN-1][ELEM_W-1:0]    vec,
  output logic                              last
);

  localparam int KW = $clog2(VEC_LEN + 1);

  logic [KW-1:0] k;

  // The final cycle only collects the last element, so no address is issued and
  // the sweep never runs past base+VEC_LEN-1.
  assign last = en && (k == KW'(VEC_LEN));
  assign addr = (en && !last) ? base + AW'(k) : '0;

  // Elements shift in from the high-index end; after VEC_LEN captures element 0 sits at vec[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k   <= '0;
      vec <= '0;
    end else if (en) begin
      if (k != '0) begin
        vec <= {vec[1:VEC_LEN-1], rdata};
      end
      k <= last ? '0 : k + 1'b1;
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - tiles C = A x B over one dot-product engine via start/done handshake
// Optional wait-for-done watchdog: DONE_TIMEOUT_EN
module matmul_sequencer
  import npu_pkg::*;
#(
  parameter int N           = 4,
  parameter int VEC_LEN     = VEC_LEN_DEFAULT,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             go,
  output logic                             busy,
  output logic                             done_all,
  output logic                             err,
  output logic [$clog2(N*VEC_LEN)-1:0]     a_raddr,
  input  logic [ELEM_W-1:0]                a_rdata,
  output logic [$clog2(N*VEC_LEN)-1:0]     b_raddr,
  input  logic [ELEM_W-1:0]                b_rdata,
  output logic [0:VEC_LEN-1][ELEM_W-1:0]   eng_a,
  output logic [0:VEC_LEN-1][ELEM_W-1:0]   eng_b,
  output logic                             eng_start,
  input  logic                             eng_done,
  input  logic [ACC_W-1:0]                 eng_c,
  output logic                             res_we,
  output logic [$clog2(N*N)-1:0]           res_waddr,
  output logic [ACC_W-1:0]                 res_wdata
);

  localparam int AW = $clog2(N*VEC_LEN);
  localparam int RW = $clog2(N*N);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  seq_state_t       state;
  seq_state_t       state_next;
  logic [IW-1:0]    i;
  logic [IW-1:0]    j;
  logic             armed;
  logic [ACC_W-1:0] c_q;
  logic             done_ok;
  logic             timed_out;
  logic             a_last;
  logic             b_last;
  logic [AW-1:0]    a_base;
  logic [AW-1:0]    b_base;

  // A done level left over from the previous result only counts once it has been seen low.
  assign done_ok = armed && eng_done;

  assign a_base = AW'(i * VEC_LEN);
  assign b_base = AW'(j * VEC_LEN);

  vec_gather #(.VEC_LEN(VEC_LEN), .AW(AW)) u_gather_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == LOAD_A),
    .base  (a_base),
    .addr  (a_raddr),
    .rdata (a_rdata),
    .vec   (eng_a),
    .last  (a_last)
  );

  vec_gather #(.VEC_LEN(VEC_LEN), .AW(AW)) u_gather_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == LOAD_B),
    .base  (b_base),
    .addr  (b_raddr),
    .rdata (b_rdata),
    .vec   (eng_b),
    .last  (b_last)
  );

`ifdef DONE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  assign timed_out = (state == WAIT) && !done_ok && (wait_cnt == TW'(TIMEOUT_CYC - 1));
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && go) begin
        err_q <= 1'b0;
      end else if (timed_out) begin
        err_q <= 1'b1;
      end
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
    end
  end
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done_all   = 1'b0;
    eng_start  = 1'b0;
    res_we     = 1'b0;
    res_waddr  = '0;
    res_wdata  = '0;
    case (state)
      IDLE:   if (go) state_next = LOAD_A;
      LOAD_A: if (a_last) state_next = LOAD_B;
      LOAD_B: if (b_last) state_next = START;
      START: begin
        eng_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (done_ok) begin
          state_next = WRITE;
        end else if (timed_out) begin
          state_next = DONE;
        end
      end
      WRITE: begin
        res_we     = 1'b1;
        res_waddr  = RW'(i * N + j);
        res_wdata  = c_q;
        state_next = NEXT;
      end
      NEXT: begin
        if (j != IW'(N - 1)) begin
          state_next = LOAD_B;
        end else if (i != IW'(N - 1)) begin
          state_next = LOAD_A;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_all   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i     <= '0;
      j     <= '0;
      armed <= 1'b0;
      c_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            i <= '0;
            j <= '0;
          end
        end
        START: armed <= 1'b0;
        WAIT: begin
          if (!eng_done) armed <= 1'b1;
          if (done_ok) c_q <= eng_c;
        end
        NEXT: begin
          if (j != IW'(N - 1)) begin
            j <= j + 1'b1;
          end else begin
            j <= '0;
            if (i != IW'(N - 1)) i <= i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - randomized job-level bench for matmul_sequencer against a matrix-product model
module tb_matmul_sequencer;

  localparam int N    = 2;
  localparam int V    = 32;
  localparam int AW   = $clog2(N*V);
  localparam int RW   = $clog2(N*N);
  localparam int TCYC = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  go = 1'b0;
  logic                  busy, done_all, err;
  logic [AW-1:0]         a_raddr, b_raddr;
  logic [7:0]            a_rdata, b_rdata;
  logic [0:V-1][7:0]     eng_a, eng_b;
  logic                  eng_start;
  logic                  eng_done;
  logic [15:0]           eng_c;
  logic                  res_we;
  logic [RW-1:0]         res_waddr;
  logic [15:0]           res_wdata;

  always #5 clk = ~clk;

  matmul_sequencer #(.N(N), .VEC_LEN(V), .TIMEOUT_CYC(TCYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .busy      (busy),
    .done_all  (done_all),
    .err       (err),
    .a_raddr   (a_raddr),
    .a_rdata   (a_rdata),
    .b_raddr   (b_raddr),
    .b_rdata   (b_rdata),
    .eng_a     (eng_a),
    .eng_b     (eng_b),
    .eng_start (eng_start),
    .eng_done  (eng_done),
    .eng_c     (eng_c),
    .res_we    (res_we),
    .res_waddr (res_waddr),
    .res_wdata (res_wdata)
  );

  // Operand memories with one cycle of read latency.
  logic [7:0] mem_a [N*V];
  logic [7:0] mem_b [N*V];

  always @(posedge clk) begin
    a_rdata <= mem_a[a_raddr];
    b_rdata <= mem_b[b_raddr];
  end

  // Engine model: done stays high between jobs; after a start it may keep the stale
  // done for eng_stale cycles, then drops for eng_lat cycles and returns the product.
  int eng_lat   = 4;
  int eng_stale = 0;
  bit eng_hang  = 1'b0;
  int e_hold, e_cnt;
  bit e_pend;

  function automatic logic [15:0] dot_staged();
    logic [15:0] s = 16'd0;
    for (int k = 0; k < V; k++) s += 16'(eng_a[k]) * 16'(eng_b[k]);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_done <= 1'b0;
      eng_c    <= 16'd0;
      e_pend   <= 1'b0;
      e_hold   <= 0;
      e_cnt    <= 0;
    end else if (eng_start) begin
      e_pend <= 1'b1;
      e_hold <= eng_stale;
      e_cnt  <= eng_hang ? (1 << 30) : eng_lat;
    end else if (e_pend) begin
      if (e_hold != 0) begin
        e_hold <= e_hold - 1;
      end else if (e_cnt != 0) begin
        eng_done <= 1'b0;
        e_cnt    <= e_cnt - 1;
      end else begin
        eng_done <= 1'b1;
        eng_c    <= dot_staged();
        e_pend   <= 1'b0;
      end
    end
  end

  // Observation log of writes, done pulses and operand sweeps.
  int            wr_n = 0, done_n = 0, a_sw = 0, b_sw = 0;
  logic [RW-1:0] wr_addr [256];
  logic [15:0]   wr_data [256];

  always @(negedge clk) begin
    if (res_we && wr_n < 256) begin
      wr_addr[wr_n] = res_waddr;
      wr_data[wr_n] = res_wdata;
      wr_n = wr_n + 1;
    end
    if (done_all) done_n = done_n + 1;
    if (int'(a_raddr) % V == V - 1) a_sw = a_sw + 1;
    if (int'(b_raddr) % V == V - 1) b_sw = b_sw + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_c(input int i, input int j);
    int s = 0;
    for (int k = 0; k < V; k++) s += int'(mem_a[i*V+k]) * int'(mem_b[j*V+k]);
    return s[15:0];
  endfunction

  task automatic fill_random();
    for (int a = 0; a < N*V; a++) begin
      mem_a[a] = 8'($urandom_range(0, 255));
      mem_b[a] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic run_job(input string tag, input bit inject, input bit go_at_done);
    int wr0, dn0, as0, bs0;
    bit seen;
    wr0 = wr_n; dn0 = done_n; as0 = a_sw; bs0 = b_sw;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check($sformatf("%s_busy_on_go", tag), busy, 1);
    check($sformatf("%s_err_clear", tag), err, 0);
    seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (done_all) seen = 1'b1;
      else go = inject && busy && (c % 7 == 3);
    end
    go = 1'b0;
    check($sformatf("%s_done_seen", tag), seen, 1);
    if (go_at_done) begin
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    repeat (3) @(negedge clk);
    check($sformatf("%s_busy_after", tag), busy, 0);
    check($sformatf("%s_done_pulses", tag), done_n - dn0, 1);
    check($sformatf("%s_write_count", tag), wr_n - wr0, N*N);
    for (int r = 0; r < N*N; r++) begin
      check($sformatf("%s_waddr%0d", tag, r), wr_addr[(wr0 + r) % 256], r);
      check($sformatf("%s_wdata%0d", tag, r), wr_data[(wr0 + r) % 256], exp_c(r / N, r % N));
    end
    check($sformatf("%s_a_sweeps", tag), a_sw - as0, N);
    check($sformatf("%s_b_sweeps", tag), b_sw - bs0, N*N);
  endtask

  initial begin
    int wr0, dn0, starts, n;
    for (int a = 0; a < N*V; a++) begin
      mem_a[a] = 8'd0;
      mem_b[a] = 8'd0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done_all", done_all, 0);
    check("rst_err", err, 0);
    check("rst_res_we", res_we, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_a_raddr", a_raddr, 0);
    check("rst_b_raddr", b_raddr, 0);
    check("rst_eng_a", |eng_a, 0);
    check("rst_eng_b", |eng_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < N*V; a++) begin
      mem_a[a] = 8'd1;
      mem_b[a] = 8'd2;
    end
    check("model_ones_twos", exp_c(1, 1), 64);
    run_job("ones", 1'b0, 1'b0);

    for (int a = 0; a < N*V; a++) begin
      mem_a[a] = 8'(a / V + 1);
      mem_b[a] = 8'(a / V + 1);
    end
    check("model_rowcol", exp_c(1, 1), 128);
    run_job("rowcol", 1'b0, 1'b0);

    fill_random();
    eng_stale = 6;
    run_job("stale", 1'b0, 1'b0);
    eng_stale = 0;

    fill_random();
    run_job("inject", 1'b1, 1'b1);

    for (int t = 0; t < 3; t++) begin
      fill_random();
      eng_lat   = $urandom_range(1, 9);
      eng_stale = $urandom_range(0, 4);
      run_job($sformatf("rand%0d", t), 1'b0, 1'b0);
    end
    eng_stale = 0;

    fill_random();
    eng_lat = 8;
    wr0 = wr_n;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    starts = 0;
    for (int c = 0; c < 5000 && starts < 2; c++) begin
      @(negedge clk);
      if (eng_start) starts++;
    end
    check("mid_reach_wait2", starts, 2);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_eng_start", eng_start, 0);
    check("mid_res_we", res_we, 0);
    check("mid_done_all", done_all, 0);
    check("mid_a_raddr", a_raddr, 0);
    check("mid_b_raddr", b_raddr, 0);
    check("mid_eng_a", |eng_a, 0);
    check("mid_eng_b", |eng_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_partial_writes", wr_n - wr0, 1);
    eng_lat = 4;
    fill_random();
    run_job("after_rst", 1'b0, 1'b0);

`ifdef DONE_TIMEOUT_EN
    eng_hang = 1'b1;
    wr0 = wr_n;
    dn0 = done_n;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    starts = 0;
    for (int c = 0; c < 5000 && starts < 1; c++) begin
      @(negedge clk);
      if (eng_start) starts++;
    end
    check("to_started", starts, 1);
    n = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      n++;
      if (done_all) break;
    end
    check("to_wait_cycles", n, TCYC + 1);
    check("to_err", err, 1);
    repeat (3) @(negedge clk);
    check("to_writes", wr_n - wr0, 0);
    check("to_done_pulses", done_n - dn0, 1);
    check("to_busy_after", busy, 0);
    check("to_err_sticky", err, 1);
    eng_hang = 1'b0;
    fill_random();
    run_job("after_to", 1'b0, 1'b0);
`else
    n = 0;
    dn0 = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Initiator side of the dot-product engine start/done handshake.
- Computes C = A x B for N x N result tiles: fetches each A row and B column from byte-wide operand memories into staging vectors, pulses eng_start, waits for eng_done, then writes eng_c into the result memory.
- Sits between the NPU operand SRAMs and one dot-product engine; driven by a top-level go/done_all command pair.

Parameters:
N, 4, result matrix dimension (rows of A, columns of B)
VEC_LEN, 32, elements per dot product
TIMEOUT_CYC, 1024, max cycles waiting for eng_done (used only with DONE_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
go  input  1  start full matrix job; sampled only in IDLE
busy  output  1  high from the cycle after go accepted until done_all
done_all  output  1  one-cycle pulse when the job ends
err  output  1  sticky timeout flag, cleared by next accepted go
a_raddr  output  clog2(N*VEC_LEN)  A read address, row-major: i*VEC_LEN+k
a_rdata  input  8  A data, valid 1 cycle after a_raddr
b_raddr  output  clog2(N*VEC_LEN)  B read address, column-major: j*VEC_LEN+k
b_rdata  input  8  B data, valid 1 cycle after b_raddr
eng_a  output  8 x [0:VEC_LEN-1]  staged row vector
eng_b  output  8 x [0:VEC_LEN-1]  staged column vector
eng_start  output  1  one-cycle start pulse to engine
eng_done  input  1  engine completion, level
eng_c  input  16  engine result, valid while eng_done=1
res_we  output  1  result write strobe, one cycle
res_waddr  output  clog2(N*N)  i*N+j
res_wdata  output  16  result data

Behaviour:
- Reset: all outputs 0, eng_a/eng_b all zero, i=j=0, state IDLE, err=0.
- States:
  - IDLE: go=1 -> clear err, i=j=0 -> LOAD_A.
  - LOAD_A: issue a_raddr for k=0..VEC_LEN-1 on consecutive cycles; capture a_rdata into eng_a[k-1] a cycle later. Lasts VEC_LEN+1 cycles -> LOAD_B.
  - LOAD_B: same scheme on the B port -> START.
  - START: eng_start=1 for exactly one cycle; clear armed -> WAIT.
  - WAIT: armed sets once eng_done has been sampled 0. Completion = armed and eng_done=1; a stale done held from the previous job is ignored. On completion -> WRITE.
  - WRITE: res_we=1, res_waddr=i*N+j, res_wdata=eng_c -> NEXT.
  - NEXT:
    - j<N-1: j++ -> LOAD_B (the A row is reused).
    - else j<N-1 false and i<N-1: j=0, i++ -> LOAD_A.
    - else -> DONE.
  - DONE: done_all=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE.
- go while busy is ignored. A go in the same cycle as the done_all pulse is ignored; it is accepted on the next IDLE cycle.
- eng_a/eng_b hold their values from the end of LOAD until overwritten; they are stable through START/WAIT.
- Address arithmetic is unsigned. i*VEC_LEN+k never exceeds N*VEC_LEN-1.
- rst_n low mid-job: immediate return to reset state; no partial res_we.
- eng_c is 16 bits and is passed through unmodified; overflow is the engine's concern.

Optional Feature:
- Macro DONE_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT_CYC before completion: err<=1, skip WRITE, go to DONE (done_all still pulses).
  - Remaining results are not written.
- Undefined: WAIT blocks indefinitely; err is tied 0; no counter logic.

Decomposition:
- Package npu_pkg:
  - ELEM_W=8, ACC_W=16, default VEC_LEN.
  - State enum seq_state_t {IDLE, LOAD_A, LOAD_B, START, WAIT, WRITE, NEXT, DONE}.
- Sub-module vec_gather:
  - Drives address, captures 1-cycle-latency data into a VEC_LEN x 8 register, asserts a last flag.
  - Instantiated twice (A and B).

Test Plan:
- N=2, A all 1, B all 2, engine model returning sum(a*b) 5 cycles after start -> four writes of 64 to addresses 0,1,2,3 in order; one done_all; busy low afterward.
- A row i = i+1, B column j = j+1, N=2 -> results 1*1*32=32, 64, 64, 128 at addresses 0..3; A loaded only twice (a_raddr sweep count=2).
- Engine holds eng_done=1 continuously from the previous job -> no write until done falls and rises again.
- go pulses in LOAD_B and WAIT -> ignored, write count unchanged.
- rst_n asserted during WAIT of result 2 -> all outputs 0 next edge; new go restarts from address 0.
- DONE_TIMEOUT_EN, TIMEOUT_CYC=16, engine never completes -> err=1 after 16 WAIT cycles, no res_we, done_all pulse; next go clears err.
